// File: rtl/latch_write_sequencer.sv
// Round-robin write sequencer for a shared bank of level-sensitive D latches.
// A winning requester's data is registered onto LatchD. LatchEn is then opened
// for a fixed window, with SETUP and HOLD margins around it, so that D is
// stable on both sides of the transparent phase.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate on Req at the next edge
// SETUP   | LatchD stable, LatchEn low, waiting SETUP_CYC cycles
// OPEN    | LatchEn high (latches transparent) for OPEN_CYC cycles
// HOLD    | LatchEn low, LatchD held, Done pulses in the last cycle
module latch_write_sequencer #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    Ck,
    input  logic                    ResetN,
    input  logic [NREQ-1:0]         Req,
    input  logic [NREQ*WIDTH-1:0]   Data,
    output logic [NREQ-1:0]         Gnt,
    output logic [NREQ-1:0]         Done,
    output logic [WIDTH-1:0]        LatchD,
    output logic                    LatchEn,
    output logic                    Busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] OPEN_LD  = 8'(OPEN_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_OPEN, ST_HOLD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  latchd_q, latchd_d;
    logic              latchen_q, latchen_d;

    logic              found;
    logic [IW-1:0]     pick;
    int                idx;

    // Round-robin pick: first asserted Req scanning from ptr upward, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Phase sequencing; every output is a flop so Req/Data never reach outputs combinationally.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        latchd_d  = latchd_q;
        latchen_d = latchen_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    win_d    = pick;
                    gnt_d    = NREQ'(1) << pick;
                    latchd_d = Data[int'(pick)*WIDTH +: WIDTH];
                    cnt_d    = SETUP_LD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    cnt_d     = OPEN_LD;
                    latchen_d = 1'b1;
                    state_d   = ST_OPEN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_OPEN: begin
                if (cnt_q == 8'd0) begin
                    cnt_d     = HOLD_LD;
                    latchen_d = 1'b0;
                    state_d   = ST_HOLD;
                    // A single-cycle HOLD is also its last cycle.
                    if (HOLD_CYC == 1) done_d = gnt_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    gnt_d   = '0;
                    done_d  = '0;
                    ptr_d   = IW'((int'(win_q) + 1) % NREQ);
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) done_d = gnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops the gate immediately.
    always_ff @(posedge Ck or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            latchd_q  <= '0;
            latchen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            latchd_q  <= latchd_d;
            latchen_q <= latchen_d;
        end
    end

    assign Gnt     = gnt_q;
    assign Done    = done_q;
    assign LatchD  = latchd_q;
    assign LatchEn = latchen_q;
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: a default-timing instance and a
// SETUP=3/OPEN=1/HOLD=2 instance share stimulus; a transaction-level model
// predicts both every cycle, and directed literals pin the key scenarios.
module tb_latch_write_sequencer;

    logic        Ck = 1'b0;
    logic        ResetN = 1'b0;
    logic [3:0]  Req = '0;
    logic [31:0] Data = '0;

    logic [3:0]  gnt_o [2];
    logic [3:0]  done_o [2];
    logic [7:0]  ld_o [2];
    logic        en_o [2];
    logic        busy_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Ck = ~Ck;

    latch_write_sequencer u_a (
        .Ck(Ck), .ResetN(ResetN), .Req(Req), .Data(Data),
        .Gnt(gnt_o[0]), .Done(done_o[0]), .LatchD(ld_o[0]),
        .LatchEn(en_o[0]), .Busy(busy_o[0])
    );

    latch_write_sequencer #(.SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) u_b (
        .Ck(Ck), .ResetN(ResetN), .Req(Req), .Data(Data),
        .Gnt(gnt_o[1]), .Done(done_o[1]), .LatchD(ld_o[1]),
        .LatchEn(en_o[1]), .Busy(busy_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: j = edges since the grant edge of the current write.
    localparam int SC [2] = '{1, 3};
    localparam int OC [2] = '{2, 1};
    localparam int HC [2] = '{1, 2};
    bit         busy_m [2] = '{0, 0};
    int         j_m    [2] = '{0, 0};
    int         win_m  [2] = '{0, 0};
    int         ptr_m  [2] = '{0, 0};
    logic [7:0] ld_m   [2] = '{8'h00, 8'h00};

    always @(posedge Ck or negedge ResetN) begin
        for (int c = 0; c < 2; c++) begin
            if (!ResetN) begin
                busy_m[c] = 0; j_m[c] = 0; win_m[c] = 0; ptr_m[c] = 0; ld_m[c] = 8'h00;
            end else if (!busy_m[c]) begin
                bit got;
                got = 0;
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (ptr_m[c] + k) % 4;
                    if (!got && Req[i]) begin
                        got = 1; win_m[c] = i; ld_m[c] = Data[i*8 +: 8];
                        busy_m[c] = 1; j_m[c] = 0;
                    end
                end
            end else begin
                j_m[c]++;
                if (j_m[c] == SC[c] + OC[c] + HC[c]) begin
                    busy_m[c] = 0;
                    ptr_m[c]  = (win_m[c] + 1) % 4;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge Ck) begin
        for (int c = 0; c < 2; c++) begin
            logic [3:0] eg, ed;
            logic       ee;
            eg = busy_m[c] ? 4'(1 << win_m[c]) : 4'h0;
            ee = busy_m[c] && (j_m[c] >= SC[c]) && (j_m[c] < SC[c] + OC[c]);
            ed = (busy_m[c] && j_m[c] == SC[c] + OC[c] + HC[c] - 1) ? eg : 4'h0;
            chk($sformatf("model_gnt[%0d]", c),  32'(gnt_o[c]),  32'(eg));
            chk($sformatf("model_done[%0d]", c), 32'(done_o[c]), 32'(ed));
            chk($sformatf("model_en[%0d]", c),   32'(en_o[c]),   32'(ee));
            chk($sformatf("model_ld[%0d]", c),   32'(ld_o[c]),   32'(ld_m[c]));
            chk($sformatf("model_busy[%0d]", c), 32'(busy_o[c]), 32'(busy_m[c]));
        end
    end

    // Grant log of the default instance (index and data at each new grant).
    int         glog [$];
    logic [7:0] dlog [$];
    logic [3:0] prev_g = '0;
    always @(negedge Ck) begin
        if (gnt_o[0] != 4'h0 && prev_g == 4'h0) begin
            for (int i = 0; i < 4; i++) if (gnt_o[0][i]) glog.push_back(i);
            dlog.push_back(ld_o[0]);
        end
        prev_g = gnt_o[0];
    end

    task automatic tick();
        @(negedge Ck);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
    endtask

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    initial begin
        logic [6:0] ea, da, ba, eb, db, bb;
        int         exp_ord [5];
        logic [7:0] exp_dat [5];

        // Reset state
        repeat (2) tick();
        chk("rst_gnt",  32'(gnt_o[0]), 32'h0);
        chk("rst_ld",   32'(ld_o[0]),  32'h0);
        chk("rst_en",   32'(en_o[0]),  32'h0);
        chk("rst_busy", 32'(busy_o[0]), 32'h0);
        ResetN = 1'b1;
        tick();

        // Single write from requester 0; also the long-setup instance timing
        Req = 4'b0001; Data = 32'h0000_00A5;
        for (int j = 0; j < 7; j++) begin
            tick();
            if (j == 0) begin
                chk("t1_gnt", 32'(gnt_o[0]), 32'h1);
                chk("t1_ld",  32'(ld_o[0]),  32'hA5);
                chk("t1_en0", 32'(en_o[0]),  32'h0);
                Req = 4'b0000;
            end
            ea[j] = en_o[0]; da[j] = done_o[0][0]; ba[j] = busy_o[0];
            eb[j] = en_o[1]; db[j] = done_o[1][0]; bb[j] = busy_o[1];
        end
        chk("t1_en_pattern",   32'(ea), 32'b0000110);
        chk("t1_done_pattern", 32'(da), 32'b0001000);
        chk("t1_busy_pattern", 32'(ba), 32'b0001111);
        chk("t6_en_pattern",   32'(eb), 32'b0001000);
        chk("t6_done_pattern", 32'(db), 32'b0100000);
        chk("t6_busy_pattern", 32'(bb), 32'b0111111);

        // All four requesting: round robin 0,1,2,3,0
        do_reset();
        glog.delete(); dlog.delete();
        Data = 32'h4433_2211; Req = 4'b1111;
        repeat (21) tick();
        Req = 4'b0000;
        repeat (12) tick();
        exp_ord = '{0, 1, 2, 3, 0};
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        chk("t2_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_order[%0d]", i), 32'(gl(i)), 32'(exp_ord[i]));
            chk($sformatf("t2_data[%0d]", i),
                32'(i < dlog.size() ? dlog[i] : 8'hxx), 32'(exp_dat[i]));
        end

        // Requester 0 joins mid-transaction: order 1,2,0
        do_reset();
        glog.delete(); dlog.delete();
        Req = 4'b0110;
        repeat (2) tick();
        Req = 4'b0111;
        repeat (9) tick();
        Req = 4'b0000;
        repeat (12) tick();
        chk("t3_count", 32'(glog.size()), 32'd3);
        chk("t3_order0", 32'(gl(0)), 32'd1);
        chk("t3_order1", 32'(gl(1)), 32'd2);
        chk("t3_order2", 32'(gl(2)), 32'd0);

        // Data changes during OPEN do not reach LatchD
        Req = 4'b0001; Data = 32'h0000_00A5;
        tick();
        chk("t4_ld_grant", 32'(ld_o[0]), 32'hA5);
        Req = 4'b0000;
        tick();
        Data = 32'h0000_003C;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("t4_ld_frozen[%0d]", j), 32'(ld_o[0]), 32'hA5);
        end
        Req = 4'b0001;
        tick();
        chk("t4_ld_new", 32'(ld_o[0]), 32'h3C);
        Req = 4'b0000;

        // Reset asserted mid-OPEN clears outputs at once
        tick();
        chk("t5_pre_en", 32'(en_o[0]), 32'h1);
        #2 ResetN = 1'b0;
        #1;
        chk("t5_en",   32'(en_o[0]),   32'h0);
        chk("t5_gnt",  32'(gnt_o[0]),  32'h0);
        chk("t5_done", 32'(done_o[0]), 32'h0);
        chk("t5_ld",   32'(ld_o[0]),   32'h0);
        chk("t5_ld_b", 32'(ld_o[1]),   32'h0);
        tick();
        ResetN = 1'b1;
        glog.delete(); dlog.delete();
        Req = 4'b0011;
        tick();
        chk("t5_ptr0", 32'(gnt_o[0]), 32'h1);
        Req = 4'b0000;
        repeat (6) tick();
        Req = 4'b1000;
        tick();
        chk("t5_gnt3", 32'(gnt_o[0]), 32'h8);
        Req = 4'b0000;
        repeat (10) tick();
        chk("t5_count", 32'(glog.size()), 32'd2);
        chk("t5_order1", 32'(gl(1)), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

endmodule
